// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle signed/unsigned restoring divider with flush and fast paths
module div_sequencer #(
  parameter int WIDTH      = 32,
  parameter int COUNT_BITS = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  input  logic             flush,
  input  logic             ack,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             has_overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                state, state_nxt;
  logic                  sgn_r;
  logic                  neg_q_r;
  logic                  neg_r_r;
  logic [WIDTH-1:0]      a_r;       // dividend, then shifts into the quotient
  logic [WIDTH-1:0]      b_r;       // divisor magnitude
  logic [WIDTH-1:0]      rem_r;     // partial remainder
  logic [COUNT_BITS-1:0] counter;

  logic                  denom_zero;
  logic                  signed_ovf;
  logic [WIDTH:0]        shifted;
  logic [WIDTH:0]        diff;
  logic                  borrow;

  assign ready = (state == S_IDLE);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

  // Fast-path detection on the live operands and the single restoring step
  always_comb begin
    denom_zero = (denom == '0);
    signed_ovf = is_signed && (numer == MIN_NEG) && (denom == '1);
    shifted    = {rem_r, a_r[WIDTH-1]};
    diff       = shifted - {1'b0, b_r};
    borrow     = diff[WIDTH];
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every other request
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = (denom_zero || signed_ovf) ? S_DONE : S_PREP;
          end
        end
        S_PREP: state_nxt = S_RUN;
        S_RUN: begin
          if (counter == '0) begin
            state_nxt = S_FIX;
          end
        end
        S_FIX:  state_nxt = S_DONE;
        S_DONE: begin
          if (ack) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, magnitude prep, iteration and sign fix-up; results only move on DONE entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sgn_r        <= 1'b0;
      neg_q_r      <= 1'b0;
      neg_r_r      <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      rem_r        <= '0;
      counter      <= '0;
      quotient     <= '0;
      remainder    <= '0;
      has_overflow <= 1'b0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sgn_r <= is_signed;
            a_r   <= numer;
            b_r   <= denom;
            if (denom_zero) begin
              quotient     <= '1;
              remainder    <= numer;
              has_overflow <= 1'b1;
            end else if (signed_ovf) begin
              quotient     <= MIN_NEG;
              remainder    <= '0;
              has_overflow <= 1'b1;
            end
          end
        end
        S_PREP: begin
          if (sgn_r && a_r[WIDTH-1]) begin
            a_r <= -a_r;
          end
          if (sgn_r && b_r[WIDTH-1]) begin
            b_r <= -b_r;
          end
          neg_q_r <= sgn_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_r_r <= sgn_r && a_r[WIDTH-1];
          rem_r   <= '0;
          counter <= COUNT_BITS'(WIDTH - 1);
        end
        S_RUN: begin
          rem_r   <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          a_r     <= {a_r[WIDTH-2:0], ~borrow};
          counter <= counter - COUNT_BITS'(1);
        end
        S_FIX: begin
          quotient     <= neg_q_r ? -a_r : a_r;
          remainder    <= neg_r_r ? -rem_r : rem_r;
          has_overflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller and iterative datapath for 32-bit signed and unsigned division.
- Sits beside the execute stage and replaces its fixed delay-count stall on divide operations.
- The execute stage issues an operation with start and stalls (holds its upstream) while busy. It consumes the quotient and remainder when done is asserted, then acknowledges.
- Supports flush abort and fast paths for divide-by-zero and signed overflow.

Parameters:
- WIDTH, 32, operand and result width in bits.
- COUNT_BITS, 6, width of the iteration counter; must satisfy 2**COUNT_BITS > WIDTH.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a division; accepted only when ready=1.
- is_signed  input  1  1 = signed division (operation 6), 0 = unsigned (operation 7); sampled at accept.
- numer  input  WIDTH  dividend, sampled at accept.
- denom  input  WIDTH  divisor, sampled at accept.
- flush  input  1  abort any operation in progress.
- ack  input  1  consumer has taken the result.
- ready  output  1  idle and able to accept start.
- busy  output  1  operation in progress or result not yet acknowledged; drives the execute-stage hold.
- done  output  1  result valid.
- quotient  output  WIDTH  quotient result.
- remainder  output  WIDTH  remainder result.
- has_overflow  output  1  divide-by-zero or signed overflow flag.

Behaviour:
Clock and reset:
- One clock, clock; reset is asynchronous and active-low, reset_n.
- Reset forces state=IDLE, done=0, has_overflow=0, quotient=0, remainder=0, counter=0. ready=1 and busy=0 immediately after reset.

States:
- IDLE: ready=1, busy=0. On start=1 it captures operands, latched into internal registers: is_signed, numer and denom.
  - denom==0: go to DONE with quotient=all ones, remainder=numer, has_overflow=1.
  - Signed, numer==0x80000000 and denom==all ones: go to DONE with quotient=0x80000000, remainder=0, has_overflow=1.
  - Otherwise: go to PREP.
- PREP (1 cycle): form the absolute values of the operands when signed, and record both sign bits. Clear the partial remainder, load counter=WIDTH-1, then go to RUN.
- RUN (WIDTH cycles): one restoring shift-subtract step per cycle, taking the MSB first. Subtraction is WIDTH+1 bits wide so the borrow is explicit. When the step with counter==0 completes, go to FIX.
- FIX (1 cycle):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if numer was negative, so the remainder takes the sign of the dividend and truncates toward zero.
  - Set has_overflow=0, then go to DONE.
- DONE: done=1, busy=1, and outputs are stable.
  - On ack=1, go to IDLE: done=0 and ready=1 from the next cycle.
  - start is ignored in DONE; there is no back-to-back accept in the same cycle as ack.

Latency:
- Normal path: done rises WIDTH+2 cycles after the accepting edge, which is 34 for WIDTH=32.
- Fast paths: done rises 1 cycle after the accepting edge.

busy:
- busy = state != IDLE, a registered-state decode.

flush:
- Takes priority over everything, including start, ack and fast paths.
- In any state, the next state is IDLE with done=0.
- quotient, remainder and has_overflow keep their last values.
- start coincident with flush is not accepted.

Stability:
- Output registers change only on entry to DONE (fast path or FIX) and at reset.
- quotient and remainder are never modified while done=1.

Reset mid-operation:
- Returns immediately to the reset state. No result is produced.

Consumer obligations:
- numer and denom must be held while start=1. After the accept edge they may change freely.

Test Plan:
- Unsigned 100/7: exactly 34 cycles after accept, done=1, quotient=14, remainder=2, has_overflow=0. done holds until ack and ready rises the cycle after ack.
- Signed -7/2 (numer=0xFFFFFFF9, denom=2): quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7/-2 gives quotient=-3, remainder=1.
- Fast paths:
  - Unsigned 5/0: done 1 cycle after accept, quotient=0xFFFFFFFF, remainder=5, has_overflow=1.
  - Signed 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0, has_overflow=1.
- Unsigned 0xFFFFFFFF/1: quotient=0xFFFFFFFF, remainder=0. Unsigned 3/0xFFFFFFFF: quotient=0, remainder=3 (full-width borrow check).
- Flush in RUN at cycle 10 after accept: next cycle state=IDLE, ready=1, done stays 0, and outputs keep the previous result. A following 9/3 gives quotient=3, remainder=0.
- Reset asserted mid-RUN, then released: ready=1, done=0, quotient=0, remainder=0. start and ack both high in the same cycle while in DONE: result acknowledged, the new start is not accepted, busy=0 next cycle.
